// File: rtl/latency_window_ctrl_if.sv
// Bus between latency_window_ctrl (master) and the latency counter block (slave):
// gated event strobes and clear going out, registered counts coming back.
interface latency_window_ctrl_if #(
  parameter int unsigned W = 32
) ();
  logic         issue_o;
  logic         retire_o;
  logic         clear_o;
  logic [W-1:0] issue_cnt_r;
  logic [W-1:0] aggregate_cnt_r;

  modport master (
    output issue_o,
    output retire_o,
    output clear_o,
    input  issue_cnt_r,
    input  aggregate_cnt_r
  );

  modport slave (
    input  issue_o,
    input  retire_o,
    input  clear_o,
    output issue_cnt_r,
    output aggregate_cnt_r
  );
endinterface

// File: rtl/latency_window_ctrl.sv
// Measurement-window sequencer for the latency counter: clear, gated run, drain, snapshot and
// a W-cycle restoring divide. Define LAT_WIN_DRAIN_TIMEOUT_EN to bound DRAIN at DRAIN_MAX cycles.
module latency_window_ctrl #(
  parameter int unsigned W         = 32,
  parameter int unsigned DRAIN_MAX = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [W-1:0]          window_len,
  input  logic                  issue_in,
  input  logic                  retire_in,
  latency_window_ctrl_if.master lat,
  output logic                  busy,
  output logic                  done,
  output logic [W-1:0]          snap_issue,
  output logic [W-1:0]          snap_agg,
  output logic [W-1:0]          avg_lat,
  output logic                  zero_issue,
  output logic                  drain_timeout
);

  localparam int unsigned CntW = $clog2(W + 1);

  typedef enum logic [2:0] {
    StIdle, StClear, StRun, StDrain, StSettle, StSnap, StDiv, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    win_cnt_q, win_cnt_d;
  logic [W-1:0]    outstanding_q, outstanding_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [CntW-1:0] div_cnt_q, div_cnt_d;
  logic [W-1:0]    snap_issue_q, snap_issue_d;
  logic [W-1:0]    snap_agg_q, snap_agg_d;
  logic [W-1:0]    avg_q, avg_d;
  logic            zero_issue_q, zero_issue_d;
  logic            issue_gated, retire_gated, clear_gated;
  logic            drain_expired;

  // One restoring-divide step; the divisor is the captured issue count.
  logic [W:0] rem_shift, rem_sub;
  logic       rem_ge;
  assign rem_shift = {rem_q, quo_q[W-1]};
  assign rem_sub   = rem_shift - {1'b0, snap_issue_q};
  assign rem_ge    = rem_shift >= {1'b0, snap_issue_q};

  always_comb begin
    state_d       = state_q;
    win_cnt_d     = win_cnt_q;
    outstanding_d = outstanding_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    div_cnt_d     = div_cnt_q;
    snap_issue_d  = snap_issue_q;
    snap_agg_d    = snap_agg_q;
    avg_d         = avg_q;
    zero_issue_d  = zero_issue_q;
    issue_gated   = 1'b0;
    retire_gated  = 1'b0;
    clear_gated   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StClear;
          win_cnt_d    = window_len;
          zero_issue_d = 1'b0;
        end
      end
      StClear: begin
        clear_gated   = 1'b1;
        outstanding_d = '0;
        state_d       = (win_cnt_q == '0) ? StDrain : StRun;
      end
      StRun: begin
        issue_gated   = issue_in && (outstanding_q != '1);
        retire_gated  = retire_in && ((outstanding_q != '0) || issue_gated);
        outstanding_d = outstanding_q + W'(issue_gated) - W'(retire_gated);
        win_cnt_d     = win_cnt_q - W'(1);
        if (win_cnt_q == W'(1)) state_d = StDrain;
      end
      StDrain: begin
        retire_gated  = retire_in && (outstanding_q != '0);
        outstanding_d = outstanding_q - W'(retire_gated);
        if ((outstanding_q == '0) || drain_expired) state_d = StSettle;
      end
      StSettle: state_d = StSnap;
      StSnap: begin
        snap_issue_d = lat.issue_cnt_r;
        snap_agg_d   = lat.aggregate_cnt_r;
        zero_issue_d = (lat.issue_cnt_r == '0);
        rem_d        = '0;
        quo_d        = lat.aggregate_cnt_r;
        div_cnt_d    = '0;
        state_d      = StDiv;
      end
      StDiv: begin
        quo_d     = {quo_q[W-2:0], rem_ge};
        rem_d     = rem_ge ? rem_sub[W-1:0] : rem_shift[W-1:0];
        div_cnt_d = div_cnt_q + CntW'(1);
        if (div_cnt_q == CntW'(W - 1)) begin
          state_d = StDone;
          avg_d   = zero_issue_q ? '0 : quo_d;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort leaves outstanding stale on purpose; the next CLEAR resets it.
    if (abort && (state_q != StIdle)) begin
      state_d       = StIdle;
      issue_gated   = 1'b0;
      retire_gated  = 1'b0;
      clear_gated   = 1'b0;
      outstanding_d = outstanding_q;
      win_cnt_d     = win_cnt_q;
      snap_issue_d  = snap_issue_q;
      snap_agg_d    = snap_agg_q;
      zero_issue_d  = zero_issue_q;
      avg_d         = avg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      win_cnt_q     <= '0;
      outstanding_q <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      div_cnt_q     <= '0;
      snap_issue_q  <= '0;
      snap_agg_q    <= '0;
      avg_q         <= '0;
      zero_issue_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_cnt_q     <= win_cnt_d;
      outstanding_q <= outstanding_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      div_cnt_q     <= div_cnt_d;
      snap_issue_q  <= snap_issue_d;
      snap_agg_q    <= snap_agg_d;
      avg_q         <= avg_d;
      zero_issue_q  <= zero_issue_d;
    end
  end

`ifdef LAT_WIN_DRAIN_TIMEOUT_EN
  localparam int unsigned DrainCntW = $clog2(DRAIN_MAX + 1);

  logic [DrainCntW-1:0] drain_cnt_q, drain_cnt_d;
  logic                 drain_timeout_q, drain_timeout_d;

  assign drain_expired = (drain_cnt_q == DrainCntW'(DRAIN_MAX - 1));

  always_comb begin
    drain_cnt_d     = '0;
    drain_timeout_d = drain_timeout_q;
    if ((state_q == StIdle) && start) drain_timeout_d = 1'b0;
    if ((state_q == StDrain) && !abort) begin
      drain_cnt_d = drain_cnt_q + DrainCntW'(1);
      if ((outstanding_q != '0) && drain_expired) drain_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt_q     <= '0;
      drain_timeout_q <= 1'b0;
    end else begin
      drain_cnt_q     <= drain_cnt_d;
      drain_timeout_q <= drain_timeout_d;
    end
  end

  assign drain_timeout = drain_timeout_q;
`else
  // DRAIN_MAX only sizes the timeout counter, which is absent in this build.
  logic unused_drain_max;
  assign unused_drain_max = ^DRAIN_MAX;
  assign drain_expired    = 1'b0;
  assign drain_timeout    = 1'b0;
`endif

  assign lat.issue_o  = issue_gated;
  assign lat.retire_o = retire_gated;
  assign lat.clear_o  = clear_gated;
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign snap_issue   = snap_issue_q;
  assign snap_agg     = snap_agg_q;
  assign avg_lat      = avg_q;
  assign zero_issue   = zero_issue_q;

endmodule

// File: tb/tb_latency_window_ctrl.sv
// Bench for latency_window_ctrl: table of windows against a stubbed counter block, a result
// scoreboard, plus hand sequences for gating, abort, reset-mid-divide and drain timeout.
module tb_latency_window_ctrl;
  localparam int unsigned W        = 32;
  localparam int unsigned DrainMax = 16;

  logic         clk = 1'b0;
  logic         rst, start, abort, issue_in, retire_in;
  logic [W-1:0] window_len;
  logic         busy, done, zero_issue, drain_timeout;
  logic [W-1:0] snap_issue, snap_agg, avg_lat;

  latency_window_ctrl_if #(.W(W)) lat_if ();

  latency_window_ctrl #(.W(W), .DRAIN_MAX(DrainMax)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .window_len    (window_len),
    .issue_in      (issue_in),
    .retire_in     (retire_in),
    .lat           (lat_if),
    .busy          (busy),
    .done          (done),
    .snap_issue    (snap_issue),
    .snap_agg      (snap_agg),
    .avg_lat       (avg_lat),
    .zero_issue    (zero_issue),
    .drain_timeout (drain_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] snap_issue;
    logic [W-1:0] snap_agg;
    logic [W-1:0] avg;
    logic         zero;
  } exp_t;

  typedef struct {
    int           len;
    logic [W-1:0] ic;
    logic [W-1:0] agg;
    logic [W-1:0] avg;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Runs one window; imask/rmask bit k drives issue_in/retire_in in cycle k after accept.
  task automatic run_win(input int len, input logic [W-1:0] ic, input logic [W-1:0] agg,
                         input logic [W-1:0] exp_avg, input logic [63:0] imask,
                         input logic [63:0] rmask, output int lat, output int n_clr,
                         output int n_iss, output int n_ret);
    exp_t e;
    @(negedge clk);
    lat_if.issue_cnt_r     = ic;
    lat_if.aggregate_cnt_r = agg;
    window_len             = W'(len);
    start                  = 1'b1;
    e.snap_issue = ic;
    e.snap_agg   = agg;
    e.avg        = exp_avg;
    e.zero       = (ic == '0);
    sb.push_back(e);
    lat = -1; n_clr = 0; n_iss = 0; n_ret = 0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      start     = 1'b0;
      issue_in  = (k < 64) ? imask[k] : 1'b0;
      retire_in = (k < 64) ? rmask[k] : 1'b0;
      #1;
      if (lat_if.clear_o)  n_clr++;
      if (lat_if.issue_o)  n_iss++;
      if (lat_if.retire_o) n_ret++;
      if (done) begin
        lat = k - 1;
        break;
      end
    end
    issue_in  = 1'b0;
    retire_in = 1'b0;
    if (lat < 0) begin
      chk("done_within_budget", W'(done), W'(1));
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk("snap_issue", snap_issue, e.snap_issue);
      chk("snap_agg",   snap_agg,   e.snap_agg);
      chk("avg_lat",    avg_lat,    e.avg);
      chk("zero_issue", W'(zero_issue), W'(e.zero));
    end
  endtask

  vec_t vecs[8];
  int   lat, n_clr, n_iss, n_ret;

  initial begin
    vecs[0] = '{len: 20, ic: 4,            agg: 30,           avg: 7};
    vecs[1] = '{len: 0,  ic: 0,            agg: 0,            avg: 0};
    vecs[2] = '{len: 3,  ic: 8,            agg: 1000,         avg: 125};
    vecs[3] = '{len: 5,  ic: 1,            agg: 32'hFFFFFFFF, avg: 32'hFFFFFFFF};
    vecs[4] = '{len: 1,  ic: 7,            agg: 6,            avg: 0};
    vecs[5] = '{len: 2,  ic: 32'hFFFFFFFF, agg: 32'hFFFFFFFE, avg: 0};
    vecs[6] = '{len: 4,  ic: 0,            agg: 123,          avg: 0};
    vecs[7] = '{len: 7,  ic: 3,            agg: 100,          avg: 33};

    rst = 1'b1; start = 1'b0; abort = 1'b0; issue_in = 1'b0; retire_in = 1'b0;
    window_len = '0; lat_if.issue_cnt_r = '0; lat_if.aggregate_cnt_r = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy",          W'(busy),            W'(0));
    chk("rst_done",          W'(done),            W'(0));
    chk("rst_snap_issue",    snap_issue,          W'(0));
    chk("rst_snap_agg",      snap_agg,            W'(0));
    chk("rst_avg_lat",       avg_lat,             W'(0));
    chk("rst_zero_issue",    W'(zero_issue),      W'(0));
    chk("rst_drain_timeout", W'(drain_timeout),   W'(0));
    chk("rst_clear_o",       W'(lat_if.clear_o),  W'(0));
    @(negedge clk);
    rst = 1'b0;

    // Events and abort while idle must not reach the counter or start anything.
    issue_in = 1'b1; retire_in = 1'b1; abort = 1'b1;
    #1;
    chk("idle_issue_blocked",  W'(lat_if.issue_o),  W'(0));
    chk("idle_retire_blocked", W'(lat_if.retire_o), W'(0));
    @(negedge clk);
    issue_in = 1'b0; retire_in = 1'b0; abort = 1'b0;
    #1;
    chk("idle_abort_no_effect", W'(busy), W'(0));

    for (int i = 0; i < 8; i++) begin
      run_win(vecs[i].len, vecs[i].ic, vecs[i].agg, vecs[i].avg, '0, '0,
              lat, n_clr, n_iss, n_ret);
      chk($sformatf("vec%0d_latency", i), W'(lat), W'(1 + vecs[i].len + 1 + 2 + W));
      chk($sformatf("vec%0d_clear_pulses", i), W'(n_clr), W'(1));
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d_done_one_cycle", i), W'(done), W'(0));
      chk($sformatf("vec%0d_idle_after", i), W'(busy), W'(0));
    end

    // Issue in RUN cycle 5, lone retire in RUN cycle 2 (blocked), issue in DRAIN cycle 2
    // (blocked), retire in DRAIN cycle 3; DRAIN then exits after its 4th cycle.
    run_win(10, 2, 10, 5, 64'h1 << 6 | 64'h1 << 13, 64'h1 << 3 | 64'h1 << 14,
            lat, n_clr, n_iss, n_ret);
    chk("gate_latency",      W'(lat),   W'(1 + 10 + 4 + 2 + W));
    chk("gate_issue_count",  W'(n_iss), W'(1));
    chk("gate_retire_count", W'(n_ret), W'(1));

    // Same-cycle issue and retire with nothing outstanding both pass.
    run_win(2, 3, 3, 1, 64'h1 << 2, 64'h1 << 2, lat, n_clr, n_iss, n_ret);
    chk("simul_latency",      W'(lat),   W'(1 + 2 + 1 + 2 + W));
    chk("simul_issue_count",  W'(n_iss), W'(1));
    chk("simul_retire_count", W'(n_ret), W'(1));

    // Abort at RUN cycle 10 with a start attempt at RUN cycle 4.
    @(negedge clk);
    lat_if.issue_cnt_r = 8; lat_if.aggregate_cnt_r = 1000;
    window_len = 30; start = 1'b1;
    n_clr = 0; n_iss = 0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start    = (k == 5);
      abort    = (k == 11);
      issue_in = (k == 11);
      #1;
      if (lat_if.clear_o) n_clr++;
      if (done) n_iss++;
      if (k == 11) chk("abort_gates_issue", W'(lat_if.issue_o), W'(0));
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; issue_in = 1'b0;
    #1;
    chk("abort_idle",            W'(busy),  W'(0));
    chk("abort_no_done",         W'(n_iss), W'(0));
    chk("abort_keeps_avg",       avg_lat,   W'(1));
    chk("abort_keeps_snap",      snap_issue, W'(3));
    chk("busy_start_ignored",    W'(n_clr), W'(1));
    run_win(4, 8, 1000, 125, '0, '0, lat, n_clr, n_iss, n_ret);
    chk("restart_clear_pulse", W'(n_clr), W'(1));
    chk("restart_latency",     W'(lat),   W'(1 + 4 + 1 + 2 + W));

    // Reset at DIV cycle 15 (DIV starts at cycle len+5).
    @(negedge clk);
    lat_if.issue_cnt_r = 5; lat_if.aggregate_cnt_r = 50;
    window_len = 2; start = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      start = 1'b0;
      rst   = (k == 21);
      #1;
      if (k == 20) chk("mid_div_busy", W'(busy), W'(1));
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_div_busy",       W'(busy),           W'(0));
    chk("rst_div_snap_issue", snap_issue,         W'(0));
    chk("rst_div_snap_agg",   snap_agg,           W'(0));
    chk("rst_div_avg",        avg_lat,            W'(0));
    chk("rst_div_clear_o",    W'(lat_if.clear_o), W'(0));
    run_win(3, 8, 1000, 125, '0, '0, lat, n_clr, n_iss, n_ret);
    chk("post_rst_latency", W'(lat),   W'(1 + 3 + 1 + 2 + W));
    chk("post_rst_clear",   W'(n_clr), W'(1));

`ifdef LAT_WIN_DRAIN_TIMEOUT_EN
    run_win(3, 1, 9, 9, 64'h1 << 2, '0, lat, n_clr, n_iss, n_ret);
    chk("tmo_latency",  W'(lat),           W'(1 + 3 + DrainMax + 2 + W));
    chk("tmo_flag",     W'(drain_timeout), W'(1));
    chk("tmo_issue",    W'(n_iss),         W'(1));
    run_win(1, 2, 9, 4, '0, '0, lat, n_clr, n_iss, n_ret);
    chk("tmo_flag_cleared", W'(drain_timeout), W'(0));
`else
    @(negedge clk);
    lat_if.issue_cnt_r = 1; lat_if.aggregate_cnt_r = 9;
    window_len = 3; start = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      start    = 1'b0;
      issue_in = (k == 2);
    end
    #1;
    chk("no_tmo_still_busy", W'(busy),          W'(1));
    chk("no_tmo_flag",       W'(drain_timeout), W'(0));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("no_tmo_abort_idle", W'(busy), W'(0));
    run_win(1, 2, 9, 4, '0, '0, lat, n_clr, n_iss, n_ret);
    chk("no_tmo_recover_latency", W'(lat), W'(1 + 1 + 1 + 2 + W));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
